regfile_wb_queue: RTL

//  Write-back side of the register file. Collects results from the ALU path (ex_*) and load path (lsu_*).

---
 rtl/regfile_wb_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue for the register file.
// Accepts results from the load path (priority) and the ALU path, one per cycle.
// Stores them in a circular buffer and drains the oldest entry to the single
// regfile write port each cycle. Also answers pending-write lookups so the
// ID stage can resolve hazards against writes still in the queue.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              not_full;
  logic              lsu_acc;
  logic              ex_acc;
  logic              enq;
  logic              deq;
  logic [ADDR_W-1:0] enq_rd;
  logic [DATA_W-1:0] enq_data;
  logic [PTR_W-1:0]  idx;

  // Handshake: the load path wins; ALU is held off whenever a load is offered.
  // Both readies are forced low during reset so nothing is accepted on that edge.
  assign not_full  = (count < CNT_W'(DEPTH));
  assign lsu_ready = rdy & ~rst & not_full;
  assign ex_ready  = rdy & ~rst & not_full & ~lsu_valid;
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign ex_acc    = ex_valid & ex_ready;

  assign enq_rd    = lsu_acc ? lsu_rd   : ex_rd;
  assign enq_data  = lsu_acc ? lsu_data : ex_data;

  // Writes to x0 complete the handshake but are never stored.
  assign enq       = (lsu_acc | ex_acc) & (enq_rd != '0);

  // Drain: head entry goes straight to the write port. Gating with ~rst keeps
  // a flushed entry from leaking into the regfile on the reset edge.
  assign busy      = (count != '0);
  assign we        = rdy & ~rst & busy;
  assign deq       = we;
  assign waddr     = busy ? rd_mem[rd_ptr]   : '0;
  assign wdata     = busy ? data_mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; frozen whenever rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (enq && !deq) begin
        count <= count + CNT_W'(1);
      end else if (!enq && deq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage; only the occupancy state above needs reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= enq_rd;
      data_mem[wr_ptr] <= enq_data;
    end
  end

  // Lookup: scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_addr != '0) && (rd_mem[idx] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = data_mem[idx];
      end
    end
  end

endmodule
